// File: rtl/arm_pkg.sv
// Shared definitions for the arm_seq instruction sequencer: phase encodings,
// opcode constants and the halt sentinel word.
package arm_pkg;

  typedef enum logic [2:0] {
    ST_HALT  = 3'b000,
    ST_FETCH = 3'b001,
    ST_EXEC1 = 3'b010,
    ST_EXEC2 = 3'b100
  } state_e;

  localparam logic [3:0]  OP_LDR    = 4'b1110;
  localparam logic [3:0]  OP_BR     = 4'b0100;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  // Sign-extend an 8-bit branch displacement to pc width.
  function automatic logic [15:0] br_offset(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/arm_pc.sv
// Program counter: holds pc, applies the post-fetch increment and the
// relative-branch add. Both updates wrap modulo 2^16.
module arm_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        br_i,
  input  logic [15:0] offset_i,
  output logic [15:0] pc_o
);

  logic [15:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (inc_i) begin
      pc_d = pc_q + 16'd1;
    end else if (br_i) begin
      pc_d = pc_q + offset_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/arm_seq.sv
// Fetch/execute sequencer: one-hot phase FSM plus instruction register.
// Define ARM_SEQ_BRANCH_EN to make opcode 4'b0100 a pc-relative branch.
module arm_seq
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic [15:0] inst,
  output logic [2:0]  state,
  output logic [15:0] pc,
  output logic        halt
);

  state_e      state_d, state_q;
  logic [15:0] inst_d, inst_q;
  logic        halt_d, halt_q;
  logic        pc_inc, pc_br;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_inc  = 1'b0;
    pc_br   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          inst_d = imem_data;
          if (imem_data == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            pc_inc  = 1'b1;
            state_d = ST_EXEC1;
          end
        end
      end
      ST_EXEC1: begin
        if (inst_q[15:12] == OP_LDR) begin
          state_d = ST_EXEC2;
        end else begin
          state_d = ST_FETCH;
`ifdef ARM_SEQ_BRANCH_EN
          pc_br = (inst_q[15:12] == OP_BR);
`else
          pc_br = 1'b0;
`endif
        end
      end
      ST_EXEC2: begin
        if (dmem_ack) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    halt_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      inst_q  <= 16'h0000;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      halt_q  <= halt_d;
    end
  end

  arm_pc u_pc (
    .clk_i    (clk),
    .rst_i    (rst),
    .inc_i    (pc_inc),
    .br_i     (pc_br),
    .offset_i (br_offset(inst_q[7:0])),
    .pc_o     (pc)
  );

  assign state     = state_q;
  assign inst      = inst_q;
  assign halt      = halt_q;
  assign imem_addr = pc;
  assign imem_req  = (state_q == ST_FETCH);
  assign dmem_req  = (state_q == ST_EXEC2);

endmodule
